ysyx_24080006_ifu_prefetch: RTL and testbench
=============================================

// Module: ysyx_24080006_ifu_prefetch
// PURPOSE
//  Next-generation instruction fetch unit: streams sequential fetches on the AXI read channel with
//  up to MAX_OUTSTANDING requests in flight. Buffers returned words with their PC in a FIFO_DEPTH
//  queue feeding IDU over valid/ready. Sits between WBU/EXU redirect source and IDU; replaces the
//  one-fetch-per-retire IFU and is fully decoupled from retirement except on redirect.
// PARAMETERS
//  RST_ADDR         32'h8000_0000  address of first fetch after reset
//  FIFO_DEPTH       4              instruction queue entries (power of 2, >=2)
//  MAX_OUTSTANDING  2              max accepted-but-unanswered AR requests (1..FIFO_DEPTH)
// PORTS
//  clock          in   1   clock
//  reset          in   1   asynchronous reset, active-high
//  redir_valid    in   1   redirect request (jump/branch/trap), single-cycle pulse
//  redir_pc       in   32  redirect target
//  arvalid/arready out/in 1  AXI AR handshake
//  araddr         out  32  fetch address; arid=0, arlen=0, arsize=3'h2, arburst=2'h1 tied
//  rvalid/rready  in/out 1  AXI R handshake (single beat, rlast ignored)
//  rdata          in   32  fetched word
//  rresp          in   2   response; nonzero = access fault
//  idu_valid      out  1   queue head valid
//  idu_ready      in   1   IDU accepts head
//  idu_inst       out  32  head instruction
//  idu_pc         out  32  head PC
//  idu_fault      out  1   head fetch returned rresp!=0
// BEHAVIOUR
//  Reset (async): arvalid=0, araddr=RST_ADDR, rready=0, idu_valid=0, idu_inst=0, idu_pc=0,
//   idu_fault=0, queue empty, outstanding=0, state=RUN. Reset mid-burst: in-flight beats forgotten.
//  Credit: issue allowed iff outstanding+queue_count+arvalid < FIFO_DEPTH and outstanding+arvalid
//   < MAX_OUTSTANDING (arvalid counted as 1 while pending). rready=1 whenever not in reset.
//  AR rule: once arvalid=1, araddr held stable until arready; on handshake araddr<=araddr+4,
//   outstanding++. First arvalid rises the cycle after reset release (addr RST_ADDR).
//  R beat in RUN: push {rdata,araddr_of_request,rresp!=0}; PC tracked by a separate issue-PC
//   pointer in request order. Push visible at idu_valid next cycle (1-cycle min R->IDU latency).
//  Pop on idu_valid&&idu_ready; simultaneous push and pop allowed at full or empty.
//  FSM: RUN  - normal; on redir_valid: flush queue, latch target;
//          if outstanding==0 && !arvalid -> araddr<=redir_pc, stay RUN (new AR next cycle);
//          else -> DRAIN.
//       DRAIN - no new AR; pending arvalid kept until arready (AXI rule); all R beats discarded;
//          further redir_valid overwrites latched target; when outstanding==0 && !arvalid
//          -> araddr<=target, RUN.
//  Redirect cycle: idu_valid forced 0, no pop; any R beat arriving that cycle discarded.
//  Fault entries stay in order; fetching continues (IDU/WBU raise trap via redirect).
//  outstanding never exceeds MAX_OUTSTANDING; queue never overflows (credit guarantees).
//  Widths: all PC arithmetic 32-bit, wrap at 32'hFFFF_FFFC -> 32'h0 silently.
// CONFIGURATION
//  IFU_PERF_EN defined: extra outputs perf_fetch[31:0] (R beats pushed), perf_flush[31:0]
//   (beats discarded+entries flushed), perf_stall[31:0] (cycles idu_ready=1 && idu_valid=0);
//   reset to 0, saturate at 32'hFFFF_FFFF.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1 Reset release, memory 1-cycle latency, idu_ready=1 -> ARs at 8000_0000,_0004,_0008...;
//    idu_pc follows same order, one instruction/cycle sustained with MAX_OUTSTANDING=2.
//  2 idu_ready=0 held -> exactly FIFO_DEPTH=4 entries queued then arvalid stays 0; idu_ready=1
//    -> entries 8000_0000.._000C drained in order, fetching resumes at 8000_0010.
//  3 Redirect to 8000_0100 with 2 outstanding -> state DRAIN, both beats dropped, idu_valid=0
//    until first beat of 8000_0100; no AR before outstanding==0.
//  4 Redirect while arvalid=1, arready=0 for 3 cycles -> araddr unchanged until handshake,
//    stale beat dropped, next AR = redir_pc; second redirect in DRAIN -> latest target used.
//  5 rresp=2'b10 on word at 8000_0008 -> idu_fault=1 with idu_pc=8000_0008 only; neighbours 0.
//  6 Assert reset with 2 outstanding and queue half full -> all outputs at reset values
//    immediately (async); after release first AR at RST_ADDR, late stale beats not enqueued.

Source files
------------

// File: rtl/ysyx_24080006_ifu_prefetch.sv
// ysyx_24080006_ifu_prefetch
//   Prefetching instruction fetch unit. Streams sequential single-beat AXI
//   reads with up to MAX_OUTSTANDING requests in flight and buffers returned
//   words (with their PC and fault flag) in a FIFO_DEPTH queue for the IDU.
//   A redirect flushes the queue; in-flight beats are drained and discarded
//   before fetching resumes at the redirect target.
//   Optional macro IFU_PERF_EN adds saturating perf_fetch/perf_flush/perf_stall
//   counter outputs.
module ysyx_24080006_ifu_prefetch #(
  parameter logic [31:0] RST_ADDR        = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  output logic        idu_valid,
  input  logic        idu_ready,
  output logic [31:0] idu_inst,
  output logic [31:0] idu_pc,
  output logic        idu_fault
`ifdef IFU_PERF_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_flush,
  output logic [31:0] perf_stall
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  // Two spare bits so outstanding + queue count never overflows.
  localparam int unsigned CW = AW + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTSTANDING);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t        r_state, w_state_n;
  logic          r_arvalid, w_arvalid_n;
  logic [31:0]   r_araddr, w_araddr_n;
  logic [31:0]   r_target, w_target_n;
  logic [31:0]   r_rpc, w_rpc_n;
  logic [CW-1:0] r_out, w_out_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic          r_rready;

  logic [31:0]   r_mem_inst  [FIFO_DEPTH];
  logic [31:0]   r_mem_pc    [FIFO_DEPTH];
  logic          r_mem_fault [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;

  logic w_ar_hs, w_r_hs, w_push, w_pop, w_idu_valid, w_credit, w_idle;

  assign w_ar_hs     = r_arvalid && arready;
  assign w_r_hs      = rvalid && r_rready;
  assign w_idle      = (r_out == '0) && !r_arvalid;
  assign w_idu_valid = (r_cnt != '0) && !redir_valid;
  assign w_pop       = w_idu_valid && idu_ready;
  // A beat with nothing outstanding (e.g. left over from before reset) is dropped.
  assign w_push      = w_r_hs && (r_state == S_RUN) && !redir_valid && (r_out != '0);

  // Post-cycle outstanding count and queue occupancy.
  always_comb begin
    w_out_n = r_out;
    if (w_ar_hs) w_out_n = w_out_n + CW'(1);
    if (w_r_hs && (r_out != '0)) w_out_n = w_out_n - CW'(1);
    if (redir_valid) begin
      w_cnt_n = '0;
    end else begin
      w_cnt_n = r_cnt;
      if (w_push) w_cnt_n = w_cnt_n + CW'(1);
      if (w_pop)  w_cnt_n = w_cnt_n - CW'(1);
    end
  end

  // Credit evaluated on post-cycle counts so a handshake can be followed by
  // a new request on the very next cycle (sustains one fetch per cycle).
  assign w_credit = ((w_out_n + w_cnt_n) < DEPTH_C) && (w_out_n < MAXO_C);

  // Next-state and AR channel control.
  always_comb begin
    w_state_n   = r_state;
    w_arvalid_n = r_arvalid;
    w_araddr_n  = r_araddr;
    w_target_n  = r_target;
    w_rpc_n     = w_push ? (r_rpc + 32'd4) : r_rpc;
    case (r_state)
      S_RUN: begin
        if (w_ar_hs) w_araddr_n = r_araddr + 32'd4;
        if (redir_valid) begin
          w_target_n = redir_pc;
          if (w_idle) begin
            w_araddr_n  = redir_pc;
            w_rpc_n     = redir_pc;
            w_arvalid_n = w_credit;
          end else begin
            w_state_n   = S_DRAIN;
            w_arvalid_n = r_arvalid && !arready;
          end
        end else if (!r_arvalid || w_ar_hs) begin
          w_arvalid_n = w_credit;
        end
      end
      S_DRAIN: begin
        if (w_ar_hs) w_arvalid_n = 1'b0;
        if (redir_valid) w_target_n = redir_pc;
        if (w_idle) begin
          w_state_n  = S_RUN;
          w_araddr_n = redir_valid ? redir_pc : r_target;
          w_rpc_n    = w_araddr_n;
        end
      end
      default: ;
    endcase
  end

  // State, AR channel, PC tracking and counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_RUN;
      r_arvalid <= 1'b0;
      r_araddr  <= RST_ADDR;
      r_target  <= RST_ADDR;
      r_rpc     <= RST_ADDR;
      r_out     <= '0;
      r_cnt     <= '0;
      r_rready  <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_arvalid <= w_arvalid_n;
      r_araddr  <= w_araddr_n;
      r_target  <= w_target_n;
      r_rpc     <= w_rpc_n;
      r_out     <= w_out_n;
      r_cnt     <= w_cnt_n;
      r_rready  <= 1'b1;
    end
  end

  // Instruction queue storage and pointers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_inst[i]  <= '0;
        r_mem_pc[i]    <= '0;
        r_mem_fault[i] <= 1'b0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (redir_valid) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_mem_inst[r_wptr]  <= rdata;
        r_mem_pc[r_wptr]    <= r_rpc;
        r_mem_fault[r_wptr] <= |rresp;
        r_wptr              <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
    end
  end

  assign arvalid   = r_arvalid;
  assign araddr    = r_araddr;
  assign arid      = '0;
  assign arlen     = '0;
  assign arsize    = 3'h2;
  assign arburst   = 2'h1;
  assign rready    = r_rready;
  assign idu_valid = w_idu_valid;
  assign idu_inst  = r_mem_inst[r_rptr];
  assign idu_pc    = r_mem_pc[r_rptr];
  assign idu_fault = r_mem_fault[r_rptr];

`ifdef IFU_PERF_EN
  logic [31:0] r_perf_fetch, r_perf_flush, r_perf_stall;
  logic [31:0] w_flush_inc;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  assign w_flush_inc = (redir_valid ? 32'(r_cnt) : 32'd0)
                     + ((w_r_hs && !w_push) ? 32'd1 : 32'd0);

  // Saturating performance counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_perf_fetch <= '0;
      r_perf_flush <= '0;
      r_perf_stall <= '0;
    end else begin
      r_perf_fetch <= sat_add(r_perf_fetch, {31'd0, w_push});
      r_perf_flush <= sat_add(r_perf_flush, w_flush_inc);
      r_perf_stall <= sat_add(r_perf_stall, {31'd0, idu_ready && !w_idu_valid});
    end
  end

  assign perf_fetch = r_perf_fetch;
  assign perf_flush = r_perf_flush;
  assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_ysyx_24080006_ifu_prefetch.sv
// Scoreboard bench for ysyx_24080006_ifu_prefetch: an AXI read slave model,
// a PC-stream reference (sequential from reset / redirect target) and a
// negedge monitor comparing every IDU handshake and AR request.
module tb_ysyx_24080006_ifu_prefetch;
  localparam logic [31:0] RST_ADDR = 32'h8000_0000;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned MAXO = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_pc = 32'd0;
  logic        arvalid, arready = 1'b0;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid = 1'b0, rready;
  logic [31:0] rdata = 32'd0;
  logic [1:0]  rresp = 2'd0;
  logic        idu_valid, idu_ready = 1'b0;
  logic [31:0] idu_inst, idu_pc;
  logic        idu_fault;

  always #5 clock = ~clock;

  ysyx_24080006_ifu_prefetch #(
    .RST_ADDR(RST_ADDR), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clock(clock), .reset(reset), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .rresp(rresp), .idu_valid(idu_valid), .idu_ready(idu_ready), .idu_inst(idu_inst),
    .idu_pc(idu_pc), .idu_fault(idu_fault)
  );

  typedef struct { logic [31:0] pc; logic [31:0] inst; logic fault; } exp_t;
  typedef struct { logic [31:0] addr; int unsigned rdy; } rd_t;

  exp_t exp_q[$];
  rd_t  rd_q[$];
  int unsigned n_tests = 0, n_fail = 0;
  int unsigned cyc = 0, delivered = 0, ar_count = 0, tb_out = 0;
  int unsigned ar_pct = 100, r_pct = 100, rdy_pct = 100, lat = 1, stale_cnt = 0;
  logic        r_is_stale = 1'b0;
  logic [31:0] exp_next = RST_ADDR;
  logic        drain = 1'b1, pending = 1'b0, prev_pend = 1'b0;
  logic [31:0] target = RST_ADDR, last_ar = 32'd0, prev_addr = 32'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic fault_at(input logic [31:0] a);
    return a[6:2] == 5'd2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refill();
    exp_t e;
    while (exp_q.size() < 16) begin
      e.pc = exp_next; e.inst = mem_word(exp_next); e.fault = fault_at(exp_next);
      exp_q.push_back(e);
      exp_next = exp_next + 32'd4;
    end
  endtask

  task automatic restart_stream(input logic [31:0] a);
    exp_q.delete();
    exp_next = a;
    refill();
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    refill();
  endtask

  task automatic redirect(input logic [31:0] t);
    redir_valid = 1'b1;
    redir_pc    = t;
    restart_stream(t);
    step();
    redir_valid = 1'b0;
  endtask

  task automatic wait_deliv(input string name, input int unsigned n, input int unsigned budget);
    int unsigned d0 = delivered;
    int unsigned k = 0;
    while (delivered < d0 + n && k < budget) begin step(); k++; end
    chk(name, 32'(delivered >= d0 + n), 32'd1);
  endtask

  // Asynchronous reset mid-cycle; outputs checked before any clock edge.
  task automatic do_reset(input int unsigned stale);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_araddr", araddr, RST_ADDR);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_idu_valid", 32'(idu_valid), 32'd0);
    chk("rst_idu_inst", idu_inst, 32'd0);
    chk("rst_idu_pc", idu_pc, 32'd0);
    chk("rst_idu_fault", 32'(idu_fault), 32'd0);
    rd_q.delete();
    tb_out = 0; drain = 1'b1; target = RST_ADDR; pending = 1'b0; prev_pend = 1'b0;
    ar_count = 0;
    restart_stream(RST_ADDR);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    stale_cnt = stale;
  endtask

  // AXI read slave and IDU ready driver.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      arready   = ($urandom_range(99) < ar_pct);
      idu_ready = ($urandom_range(99) < rdy_pct);
      if (stale_cnt != 0) begin
        rvalid = 1'b1; r_is_stale = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
        stale_cnt--;
      end else if (!reset && rd_q.size() != 0 && rd_q[0].rdy <= cyc
                   && $urandom_range(99) < r_pct) begin
        rvalid = 1'b1; r_is_stale = 1'b0;
        rdata  = mem_word(rd_q[0].addr);
        rresp  = fault_at(rd_q[0].addr) ? 2'b10 : 2'b00;
      end else begin
        rvalid = 1'b0; r_is_stale = 1'b0; rdata = $urandom; rresp = 2'b00;
      end
    end
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: AR ordering/stability, outstanding bound, IDU stream scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (prev_pend) begin
          chk("ar_hold_valid", 32'(arvalid), 32'd1);
          chk("ar_hold_addr", araddr, prev_addr);
        end
        if (arvalid && arready) begin
          if (!redir_valid) begin
            if (pending) pending = 1'b0;
            else if (drain) begin
              chk("ar_drain_outstanding", tb_out, 32'd0);
              chk("ar_target", araddr, target);
              drain = 1'b0;
            end else chk("ar_sequential", araddr, last_ar + 32'd4);
          end
          chk("ar_max_outstanding", 32'(tb_out < MAXO), 32'd1);
        end
        if (rvalid && rready && !r_is_stale && rd_q.size() != 0) begin
          rd_q.delete(0);
          tb_out--;
        end
        if (arvalid && arready) begin
          rd_q.push_back('{araddr, cyc + lat});
          tb_out++;
          last_ar = araddr;
          ar_count++;
        end
        if (redir_valid) begin
          chk("idu_valid_in_redirect", 32'(idu_valid), 32'd0);
          drain = 1'b1; target = redir_pc; pending = arvalid && !arready;
        end
        if (idu_valid && idu_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL idu_unexpected: got pc %08h expected no entry", idu_pc);
          end else begin
            e = exp_q.pop_front();
            chk("idu_pc", idu_pc, e.pc);
            chk("idu_inst", idu_inst, e.inst);
            chk("idu_fault", 32'(idu_fault), 32'(e.fault));
            delivered++;
          end
        end
        prev_pend = arvalid && !arready;
        prev_addr = araddr;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d0;
    logic [31:0] held, t;
    // Reset, first AR, sustained streaming, fault entry at 8000_0008.
    do_reset(0);
    chk("tie_arid", 32'(arid), 32'd0);
    chk("tie_arlen", 32'(arlen), 32'd0);
    chk("tie_arsize", 32'(arsize), 32'd2);
    chk("tie_arburst", 32'(arburst), 32'd1);
    step();
    chk("first_arvalid", 32'(arvalid), 32'd1);
    chk("first_araddr", araddr, RST_ADDR);
    chk("rready_up", 32'(rready), 32'd1);
    repeat (7) step();
    d0 = delivered;
    repeat (20) step();
    chk("throughput_20", delivered - d0, 32'd20);

    // Back-pressure: exactly FIFO_DEPTH fetches, then resume in order.
    do_reset(0);
    rdy_pct = 0;
    repeat (30) step();
    chk("fill_ar_count", ar_count, 32'(FIFO_DEPTH));
    chk("fill_arvalid", 32'(arvalid), 32'd0);
    chk("fill_head_pc", idu_pc, RST_ADDR);
    rdy_pct = 100;
    wait_deliv("fill_drain", 12, 100);

    // Redirect with two requests in flight.
    do_reset(0);
    lat = 6;
    for (int k = 0; k < 50 && tb_out != 2; k++) step();
    chk("two_outstanding", tb_out, 32'd2);
    redirect(32'h8000_0100);
    wait_deliv("redir_drain", 8, 200);
    lat = 1;

    // Redirect while AR stalled, then second redirect during drain.
    do_reset(0);
    repeat (6) step();
    ar_pct = 0;
    step(); step();
    for (int k = 0; k < 50 && !arvalid; k++) step();
    held = araddr;
    redirect(32'h8000_0200);
    repeat (3) step();
    chk("stalled_araddr", araddr, held);
    redirect(32'h8000_0300);
    ar_pct = 100;
    wait_deliv("second_redirect", 8, 200);

    // Address wrap.
    redirect(32'hFFFF_FFF0);
    wait_deliv("wrap", 10, 200);

    // Reset with queue partly full and requests outstanding; stale beats after.
    do_reset(0);
    lat = 4; rdy_pct = 0;
    repeat (7) step();
    ar_pct = 0;
    do_reset(3);
    repeat (4) step();
    ar_pct = 100; rdy_pct = 100; lat = 1;
    wait_deliv("after_mid_reset", 8, 200);

    // Randomised traffic with random redirects.
    ar_pct = 70; r_pct = 70; rdy_pct = 75;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) lat = $urandom_range(4, 1);
      if ($urandom_range(99) < 3) begin
        t = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
        redirect(t);
      end else step();
    end
    ar_pct = 100; r_pct = 100; rdy_pct = 100;
    wait_deliv("random_progress", 8, 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
